bs_ser: RTL and testbench



---
 rtl/bs_ser_if.sv | 25 ++
 rtl/bs_ser.sv | 138 +++++++++++++
 tb/tb_bs_ser.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bs_ser_if.sv
// Operand handshake and serial output bundle for bs_ser.
// The master side presents parallel operands; the slave side returns the framed serial stream.
interface bs_ser_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             x;
    logic             y;
    logic             firstbit;
    logic             lastbit;
    logic             busy;

    modport master (
        output in_valid, in_x, in_y,
        input  in_ready, x, y, firstbit, lastbit, busy
    );

    modport slave (
        input  in_valid, in_x, in_y,
        output in_ready, x, y, firstbit, lastbit, busy
    );
endinterface

// File: rtl/bs_ser.sv
// Parallel-to-bit-serial operand serializer, LSB first, with firstbit/lastbit framing.
// Define BS_SER_BUF_EN to add a one-entry holding buffer so upstream can hand over mid-frame.
//
// state | meaning
// IDLE  | no frame on the serial lines, outputs held at 0
// SHIFT | frame in progress, cnt is the index of the bit currently on x/y
module bs_ser #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    bs_ser_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sx_q, sx_d, sy_q, sy_d;
    logic             x_q, x_d, y_q, y_d;
    logic             first_q, first_d, last_q, last_d;

    logic             in_ready;
    logic             xfer;
    logic             frame_end;
    logic             have_next;
    logic             buf_full;
    logic [WIDTH-1:0] nx, ny;

    assign frame_end = (state_q == IDLE) || (cnt_q == CNT_LAST);
    assign xfer      = bus.in_valid && in_ready;

`ifdef BS_SER_BUF_EN
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] bx_q, bx_d, by_q, by_d;

    assign in_ready = !buf_full_q;
    assign buf_full = buf_full_q;

    // A buffered word always wins over the live input at a frame boundary.
    always_comb begin
        buf_full_d = buf_full_q;
        bx_d       = bx_q;
        by_d       = by_q;
        have_next  = buf_full_q || xfer;
        nx         = buf_full_q ? bx_q : bus.in_x;
        ny         = buf_full_q ? by_q : bus.in_y;
        if (frame_end) begin
            buf_full_d = 1'b0;
        end
        if (xfer && !(frame_end && !buf_full_q)) begin
            buf_full_d = 1'b1;
            bx_d       = bus.in_x;
            by_d       = bus.in_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_q <= 1'b0;
            bx_q       <= '0;
            by_q       <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
        end
    end
`else
    assign in_ready  = frame_end;
    assign buf_full  = 1'b0;
    assign have_next = xfer;
    assign nx        = bus.in_x;
    assign ny        = bus.in_y;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        x_d     = 1'b0;
        y_d     = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        if (frame_end) begin
            cnt_d = '0;
            if (have_next) begin
                state_d = SHIFT;
                x_d     = nx[0];
                y_d     = ny[0];
                sx_d    = nx >> 1;
                sy_d    = ny >> 1;
                first_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            cnt_d  = cnt_q + 1'b1;
            x_d    = sx_q[0];
            y_d    = sy_q[0];
            sx_d   = sx_q >> 1;
            sy_d   = sy_q >> 1;
            last_d = (cnt_d == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.firstbit = first_q;
    assign bus.lastbit  = last_q;
    assign bus.busy     = (state_q == SHIFT) || buf_full;
endmodule

// File: tb/tb_bs_ser.sv
// Directed and randomized bench for bs_ser at WIDTH=8 and WIDTH=2.
module tb_bs_ser;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    bit         mon_en     = 1'b0;
    bit         mon_active = 1'b0;
    int         mon_idx    = 0;
    logic [7:0] cur_x, cur_y;
    logic [15:0] exp_q[$];

`ifdef BS_SER_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    typedef struct {
        logic [7:0] ix;
        logic [7:0] iy;
        logic [0:7] ex;
        logic [0:7] ey;
    } vec_t;

    vec_t vecs[4];

    bs_ser_if #(.WIDTH(8)) if8 ();
    bs_ser_if #(.WIDTH(2)) if2 ();

    bs_ser #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    bs_ser #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge showing bit 0 when the word starts at once.
    task automatic push_word(input logic [7:0] wx, input logic [7:0] wy, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        if8.in_valid = 1'b1;
        if8.in_x     = wx;
        if8.in_y     = wy;
        while (!if8.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("push_ready_timeout", 32'(if8.in_ready), 32'd1);
        else exp_q.push_back({wx, wy});
        @(negedge clk);
        if8.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((if8.busy || exp_q.size() != 0 || mon_active) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 32'd1);
    endtask

    // Reference model: every accepted word must appear as one contiguous framed frame, in order.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                mon_idx    = 0;
                exp_q.delete();
            end else if (mon_en) begin
                if (if8.firstbit) begin
                    chk("mon_first_in_frame", 32'(mon_active), 32'd0);
                    chk("mon_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        {cur_x, cur_y} = exp_q.pop_front();
                        mon_active = 1'b1;
                        mon_idx    = 0;
                    end
                end
                if (mon_active) begin
                    chk("mon_x", 32'(if8.x), 32'(cur_x[mon_idx]));
                    chk("mon_y", 32'(if8.y), 32'(cur_y[mon_idx]));
                    chk("mon_lastbit", 32'(if8.lastbit), 32'(mon_idx == 7));
                    chk("mon_busy", 32'(if8.busy), 32'd1);
                    mon_idx++;
                    if (mon_idx == 8) begin
                        mon_active = 1'b0;
                        mon_idx    = 0;
                    end
                end else begin
                    chk("mon_idle_outs", 32'({if8.x, if8.y, if8.lastbit, if8.busy}), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [0:23] cx;
        logic [0:23] cy;
        logic [1:0]  w2x;
        logic [1:0]  w2y;
        bit          taken;

        cx  = 24'b1000_0000_0000_0001_1111_1111;
        cy  = 24'b1111_0000_0000_1111_0011_1100;
        w2x = 2'b01;
        w2y = 2'b10;
        vecs[0] = '{8'hA5, 8'h3C, 8'b10100101, 8'b00111100};
        vecs[1] = '{8'h12, 8'hC1, 8'b01001000, 8'b10000011};
        vecs[2] = '{8'hFF, 8'h00, 8'b11111111, 8'b00000000};
        vecs[3] = '{8'h6E, 8'hB9, 8'b01110110, 8'b10011101};

        rst_n        = 1'b1;
        if8.in_valid = 1'b0;
        if8.in_x     = '0;
        if8.in_y     = '0;
        if2.in_valid = 1'b0;
        if2.in_x     = '0;
        if2.in_y     = '0;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_outs8", 32'({if8.x, if8.y, if8.firstbit, if8.lastbit, if8.busy}), 32'd0);
        chk("rst_ready8", 32'(if8.in_ready), 32'd1);
        chk("rst_outs2", 32'({if2.x, if2.y, if2.firstbit, if2.lastbit, if2.busy}), 32'd0);
        chk("rst_ready2", 32'(if2.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single frames from idle.
        for (int v = 0; v < 4; v++) begin
            push_word(vecs[v].ix, vecs[v].iy, 0);
            for (int k = 0; k < 8; k++) begin
                if (k > 0) @(negedge clk);
                chk("vec_x", 32'(if8.x), 32'(vecs[v].ex[k]));
                chk("vec_y", 32'(if8.y), 32'(vecs[v].ey[k]));
                chk("vec_firstbit", 32'(if8.firstbit), 32'(k == 0));
                chk("vec_lastbit", 32'(if8.lastbit), 32'(k == 7));
                chk("vec_busy", 32'(if8.busy), 32'd1);
                chk("vec_ready", 32'(if8.in_ready), 32'(BUF ? 1'b1 : (k == 7)));
            end
            @(negedge clk);
            chk("vec_idle_outs", 32'({if8.x, if8.y, if8.firstbit, if8.lastbit, if8.busy}), 32'd0);
            chk("vec_idle_ready", 32'(if8.in_ready), 32'd1);
        end

        // Three words back to back: 24 serial cycles with no gap.
        fork
            begin
                push_word(8'h01, 8'h0F, 0);
                push_word(8'h80, 8'hF0, 0);
                push_word(8'hFF, 8'h3C, 0);
            end
        join_none
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk("cont_x", 32'(if8.x), 32'(cx[c]));
            chk("cont_y", 32'(if8.y), 32'(cy[c]));
            chk("cont_firstbit", 32'(if8.firstbit), 32'(c % 8 == 0));
            chk("cont_lastbit", 32'(if8.lastbit), 32'(c % 8 == 7));
        end
        wait_idle();

        // Next word offered at cycle 3 of a running frame.
        push_word(8'h33, 8'hCC, 0);
        repeat (2) @(negedge clk);
        if8.in_valid = 1'b1;
        if8.in_x     = 8'h96;
        if8.in_y     = 8'h69;
        taken        = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            chk("mid_ready", 32'(if8.in_ready), 32'(BUF ? (c == 3) : (c == 8)));
            if (if8.in_ready && !taken) begin
                exp_q.push_back({8'h96, 8'h69});
                taken = 1'b1;
            end
            @(negedge clk);
            if (taken) if8.in_valid = 1'b0;
        end
        chk("mid_next_first", 32'(if8.firstbit), 32'd1);
        wait_idle();

        // Asynchronous reset in the middle of a frame.
        push_word(8'hFF, 8'hFF, 0);
        repeat (4) @(negedge clk);
        chk("pre_rst_x", 32'(if8.x), 32'd1);
        chk("pre_rst_busy", 32'(if8.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'({if8.x, if8.y, if8.firstbit, if8.lastbit, if8.busy}), 32'd0);
        chk("async_rst_ready", 32'(if8.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_word(8'h5A, 8'hC3, 0);
        chk("post_rst_first", 32'(if8.firstbit), 32'd1);
        chk("post_rst_x", 32'(if8.x), 32'd0);
        chk("post_rst_y", 32'(if8.y), 32'd1);
        wait_idle();

        // WIDTH=2 with input always available.
        if2.in_valid = 1'b1;
        if2.in_x     = w2x;
        if2.in_y     = w2y;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("w2_firstbit", 32'(if2.firstbit), 32'(c % 2 == 0));
            chk("w2_lastbit", 32'(if2.lastbit), 32'(c % 2 == 1));
            chk("w2_exclusive", 32'(if2.firstbit && if2.lastbit), 32'd0);
            chk("w2_x", 32'(if2.x), 32'(w2x[c % 2]));
            chk("w2_y", 32'(if2.y), 32'(w2y[c % 2]));
        end
        if2.in_valid = 1'b0;
        @(negedge clk);
        chk("w2_idle_outs", 32'({if2.x, if2.y, if2.firstbit, if2.lastbit, if2.busy}), 32'd0);

        // Random operands with random idle gaps between offers.
        for (int f = 0; f < 1000; f++) begin
            push_word(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end
        wait_idle();
        chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
